dtt_crossbar_switch_rr: RTL and testbench

- Buffered N_IN x N_OUT crossbar with valid/ready on both sides; successor to the unbuffered crossbar switch.
- Each input has a FIFO holding {dest, data} words.
- Each output has a round-robin arbiter and a registered output stage with backpressure, so contention is resolved without data loss.
- Sits between the packet sources and the per-port egress logic of the interconnect.

---
 rtl/dtt_crossbar_switch_rr.sv | 161 ++++++++++++++++
 tb/tb_dtt_crossbar_switch_rr.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtt_crossbar_switch_rr.sv
// Buffered N_IN x N_OUT crossbar: per-input {dest,data} FIFOs, per-output
// round-robin arbitration into a registered output stage with backpressure.
module dtt_crossbar_switch_rr #(
  parameter int N_IN       = 4,
  parameter int N_OUT      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [N_IN-1:0][DATA_WIDTH-1:0]        in_data_i,
  input  logic [N_IN-1:0][$clog2(N_OUT)-1:0]     in_dest_i,
  input  logic [N_IN-1:0]                        in_valid_i,
  output logic [N_IN-1:0]                        in_ready_o,
  output logic [N_OUT-1:0][DATA_WIDTH-1:0]       out_data_o,
  output logic [N_OUT-1:0][$clog2(N_IN)-1:0]     out_src_o,
  output logic [N_OUT-1:0]                       out_valid_o,
  input  logic [N_OUT-1:0]                       out_ready_i,
  output logic [N_IN-1:0]                        err_drop_o
);

  localparam int DEST_W = $clog2(N_OUT);
  localparam int SRC_W  = $clog2(N_IN);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_data_q [N_IN][FIFO_DEPTH];
  logic [DEST_W-1:0]     mem_dest_q [N_IN][FIFO_DEPTH];

  logic [N_IN-1:0][PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [N_IN-1:0][PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [N_IN-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [N_IN-1:0]            err_drop_q, err_drop_d;

  logic [N_OUT-1:0]                 out_valid_q, out_valid_d;
  logic [N_OUT-1:0][DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [N_OUT-1:0][SRC_W-1:0]      out_src_q, out_src_d;
  logic [N_OUT-1:0][SRC_W-1:0]      rr_ptr_q, rr_ptr_d;

  logic [N_IN-1:0]                  push, pop, empty, full, bad;
  logic [N_IN-1:0][DATA_WIDTH-1:0]  head_data;
  logic [N_IN-1:0][DEST_W-1:0]      head_dest;
  logic [N_OUT-1:0]                 load, gnt_vld;
  logic [N_OUT-1:0][SRC_W-1:0]      gnt_idx;

  // in_ready is forced low while reset is asserted, independent of occupancy
  assign in_ready_o  = ~full & {N_IN{~rst_i}};
  assign out_data_o  = out_data_q;
  assign out_src_o   = out_src_q;
  assign out_valid_o = out_valid_q;
  assign err_drop_o  = err_drop_q;

  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      empty[i]     = (cnt_q[i] == '0);
      full[i]      = (cnt_q[i] == CNT_W'(FIFO_DEPTH));
      head_data[i] = mem_data_q[i][rd_ptr_q[i]];
      head_dest[i] = mem_dest_q[i][rd_ptr_q[i]];
      bad[i]       = !empty[i] && (32'(head_dest[i]) >= 32'(N_OUT));
      push[i]      = in_valid_i[i] && in_ready_o[i];
    end
  end

  // Rotating-priority scan starting at rr_ptr_q[o], wrapping modulo N_IN
  always_comb begin
    int idx;
    idx = 0;
    for (int o = 0; o < N_OUT; o++) begin
      load[o]    = !out_valid_q[o] || out_ready_i[o];
      gnt_vld[o] = 1'b0;
      gnt_idx[o] = '0;
      for (int k = 0; k < N_IN; k++) begin
        idx = int'(rr_ptr_q[o]) + k;
        if (idx >= N_IN) idx = idx - N_IN;
        if (load[o] && !gnt_vld[o] && !empty[idx] &&
            (32'(head_dest[idx]) == 32'(o))) begin
          gnt_vld[o] = 1'b1;
          gnt_idx[o] = SRC_W'(idx);
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      pop[i] = bad[i];
      for (int o = 0; o < N_OUT; o++) begin
        if (gnt_vld[o] && (gnt_idx[o] == SRC_W'(i))) pop[i] = 1'b1;
      end
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    err_drop_d = bad;
    for (int i = 0; i < N_IN; i++) begin
      if (push[i]) wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
      if (pop[i])  rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
      unique case ({push[i], pop[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    rr_ptr_d    = rr_ptr_q;
    for (int o = 0; o < N_OUT; o++) begin
      if (load[o]) begin
        if (gnt_vld[o]) begin
          out_valid_d[o] = 1'b1;
          out_data_d[o]  = head_data[gnt_idx[o]];
          out_src_d[o]   = gnt_idx[o];
          if (gnt_idx[o] == SRC_W'(N_IN - 1)) rr_ptr_d[o] = '0;
          else                                rr_ptr_d[o] = gnt_idx[o] + SRC_W'(1);
        end else begin
          out_valid_d[o] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      err_drop_q  <= '0;
      out_valid_q <= '0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      err_drop_q  <= err_drop_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  // Storage needs no reset: push is blocked while rst_i is high
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < N_IN; i++) begin
      if (push[i]) begin
        mem_data_q[i][wr_ptr_q[i]] <= in_data_i[i];
        mem_dest_q[i][wr_ptr_q[i]] <= in_dest_i[i];
      end
    end
  end

endmodule

// File: tb/tb_dtt_crossbar_switch_rr.sv
// Bench for dtt_crossbar_switch_rr: two instances (N_OUT=4 and N_OUT=3) share
// stimulus and are checked every cycle against a queue-based reference model.
module tb_dtt_crossbar_switch_rr;
  localparam int NI = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [3:0][31:0] in_data;
  logic [3:0][1:0]  in_dest;
  logic [3:0]       in_valid;
  logic [3:0]       out_ready;

  logic [3:0]       rdy0, err0, ov0;
  logic [3:0][31:0] od0;
  logic [3:0][1:0]  os0;
  logic [3:0]       rdy1, err1;
  logic [2:0]       ov1;
  logic [2:0][31:0] od1;
  logic [2:0][1:0]  os1;

  dtt_crossbar_switch_rr #(.N_IN(4), .N_OUT(4), .DATA_WIDTH(32), .FIFO_DEPTH(4)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .in_data_i(in_data), .in_dest_i(in_dest),
    .in_valid_i(in_valid), .in_ready_o(rdy0), .out_data_o(od0), .out_src_o(os0),
    .out_valid_o(ov0), .out_ready_i(out_ready), .err_drop_o(err0));

  dtt_crossbar_switch_rr #(.N_IN(4), .N_OUT(3), .DATA_WIDTH(32), .FIFO_DEPTH(4)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .in_data_i(in_data), .in_dest_i(in_dest),
    .in_valid_i(in_valid), .in_ready_o(rdy1), .out_data_o(od1), .out_src_o(os1),
    .out_valid_o(ov1), .out_ready_i(out_ready[2:0]), .err_drop_o(err1));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int nout(input int c);
    return (c == 0) ? 4 : 3;
  endfunction

  // Reference model: queues of {dest,data} per input, output registers, RR pointers
  logic [33:0] mq [2][4][$];
  logic        m_ov  [2][4];
  logic [31:0] m_od  [2][4];
  int          m_os  [2][4];
  int          m_ptr [2][4];
  logic        m_err [2][4];

  always @(posedge clk) begin : model
    bit          pu [4];
    bit          po [4];
    bit          found;
    int          idx;
    logic [33:0] hd;
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        for (int i = 0; i < NI; i++) begin
          mq[c][i].delete();
          m_err[c][i] = 1'b0;
        end
        for (int o = 0; o < 4; o++) begin
          m_ov[c][o] = 1'b0; m_od[c][o] = '0; m_os[c][o] = 0; m_ptr[c][o] = 0;
        end
      end else begin
        for (int i = 0; i < NI; i++) begin
          pu[i] = in_valid[i] && (mq[c][i].size() < DEPTH);
          po[i] = 1'b0;
          m_err[c][i] = 1'b0;
          if (mq[c][i].size() > 0) begin
            hd = mq[c][i][0];
            if (int'(hd[33:32]) >= nout(c)) begin
              m_err[c][i] = 1'b1;
              po[i] = 1'b1;
            end
          end
        end
        for (int o = 0; o < nout(c); o++) begin
          if (!m_ov[c][o] || out_ready[o]) begin
            found = 1'b0;
            for (int k = 0; k < NI; k++) begin
              idx = (m_ptr[c][o] + k) % NI;
              if (!found && mq[c][idx].size() > 0) begin
                hd = mq[c][idx][0];
                if (int'(hd[33:32]) == o) begin
                  found = 1'b1;
                  m_od[c][o] = hd[31:0];
                  m_os[c][o] = idx;
                  m_ptr[c][o] = (idx + 1) % NI;
                  po[idx] = 1'b1;
                end
              end
            end
            m_ov[c][o] = found;
          end
        end
        for (int i = 0; i < NI; i++) begin
          if (po[i]) void'(mq[c][i].pop_front());
          if (pu[i]) mq[c][i].push_back({in_dest[i], in_data[i]});
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    logic a_rdy, a_err, a_ov;
    logic [31:0] a_od;
    logic [1:0] a_os;
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < NI; i++) begin
        a_rdy = (c == 0) ? rdy0[i] : rdy1[i];
        a_err = (c == 0) ? err0[i] : err1[i];
        chk($sformatf("in_ready c%0d i%0d", c, i), 32'(a_rdy),
            32'(!rst && (mq[c][i].size() < DEPTH)));
        chk($sformatf("err_drop c%0d i%0d", c, i), 32'(a_err), 32'(m_err[c][i]));
      end
      for (int o = 0; o < nout(c); o++) begin
        if (c == 0) begin a_ov = ov0[o]; a_od = od0[o]; a_os = os0[o]; end
        else        begin a_ov = ov1[o]; a_od = od1[o]; a_os = os1[o]; end
        chk($sformatf("out_valid c%0d o%0d", c, o), 32'(a_ov), 32'(m_ov[c][o]));
        if (m_ov[c][o]) begin
          chk($sformatf("out_data c%0d o%0d", c, o), a_od, m_od[c][o]);
          chk($sformatf("out_src c%0d o%0d", c, o), 32'(a_os), 32'(m_os[c][o]));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    in_valid  = '0;
    out_ready = '1;
    repeat (n) tick();
  endtask

  initial begin
    int k, acc, a1, prev, errcnt, ovcnt, one_cnt;
    logic [1:0] srcs [8];
    logic [31:0] got [$];

    rst = 1'b1; in_valid = '0; in_data = '0; in_dest = '0; out_ready = '1;
    tick(); tick();
    @(negedge clk);
    chk("reset in_ready", 32'(rdy0), 32'h0);
    chk("reset out_valid", 32'(ov0), 32'h0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset in_ready", 32'(rdy0), 32'hF);

    // Contention
    tick();
    in_data  = {32'h11112222, 32'hEEEEFFFF, 32'hCCCCDDDD, 32'hAAAABBBB};
    in_dest  = {2'd3, 2'd1, 2'd2, 2'd2};
    in_valid = 4'hF;
    tick();
    in_valid = '0;
    tick();
    @(negedge clk);
    chk("cont out_valid1", 32'(ov0), 32'hE);
    chk("cont out2 data", od0[2], 32'hAAAABBBB);
    chk("cont out2 src", 32'(os0[2]), 0);
    chk("cont out1 data", od0[1], 32'hEEEEFFFF);
    chk("cont out1 src", 32'(os0[1]), 2);
    chk("cont out3 data", od0[3], 32'h11112222);
    chk("cont out3 src", 32'(os0[3]), 3);
    tick();
    @(negedge clk);
    chk("cont out_valid2", 32'(ov0), 32'h4);
    chk("cont out2 data2", od0[2], 32'hCCCCDDDD);
    chk("cont out2 src2", 32'(os0[2]), 1);

    // Round-robin fairness
    idle(6);
    in_dest = '0; k = 0; a1 = 0;
    in_data[0] = 32'h100; in_data[1] = 32'h200;
    in_valid = 4'b0011;
    for (int cyc = 0; cyc < 24; cyc++) begin
      acc = int'(rdy0[0]); prev = int'(rdy0[1]);
      tick();
      if (acc != 0)  begin k++;  in_data[0] = 32'h100 + 32'(k); end
      if (prev != 0) begin a1++; in_data[1] = 32'h200 + 32'(a1); end
      @(negedge clk);
      if (cyc >= 12 && cyc < 20) srcs[cyc-12] = os0[0];
    end
    for (int j = 1; j < 8; j++)
      chk($sformatf("rr alternation %0d", j), 32'(srcs[j] != srcs[j-1]), 1);

    // Backpressure
    idle(12);
    out_ready[0] = 1'b0; in_dest = '0; in_valid = 4'b0001;
    k = 1; in_data[0] = 1;
    for (int j = 0; j < 20 && k <= 5; j++) begin
      acc = int'(rdy0[0]);
      tick();
      if (acc != 0) begin k++; in_data[0] = 32'(k); end
    end
    chk("bp accepted five", k, 6);
    tick(); tick();
    @(negedge clk);
    chk("bp in_ready low", 32'(rdy0[0]), 0);
    chk("bp held data", od0[0], 1);
    chk("bp held valid", 32'(ov0[0]), 1);
    tick();
    out_ready[0] = 1'b1;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      if (ov0[0]) got.push_back(od0[0]);
      acc = int'(rdy0[0]);
      tick();
      if (acc != 0) in_valid = '0;
    end
    chk("bp delivered count", got.size(), 6);
    for (int j = 0; j < got.size() && j < 6; j++)
      chk($sformatf("bp word %0d", j), got[j], 32'(j + 1));

    // Invalid destination on the N_OUT=3 instance
    idle(12);
    in_dest[0] = 2'd3; in_data[0] = 32'hDEADBEEF; in_valid = 4'b0001;
    tick();
    in_dest[0] = 2'd0; in_data[0] = 32'h1;
    tick();
    in_valid = '0;
    errcnt = 0; ovcnt = 0; one_cnt = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      errcnt += int'(err1[0]);
      for (int o = 0; o < 3; o++) begin
        ovcnt += int'(ov1[o]);
        if (ov1[o] && od1[o] == 32'h1 && o == 0) one_cnt++;
      end
      tick();
    end
    chk("bad dest err pulses", errcnt, 1);
    chk("bad dest out_valid cycles", ovcnt, 1);
    chk("bad dest next word", one_cnt, 1);

    // Reset mid-operation
    idle(12);
    out_ready = '0; in_dest = '0; in_valid = 4'b0001;
    k = 0; in_data[0] = 32'h31;
    for (int j = 0; j < 10 && k < 3; j++) begin
      acc = int'(rdy0[0]);
      tick();
      if (acc != 0) begin k++; in_data[0] = 32'h31 + 32'(k); end
    end
    chk("rst fill", k, 3);
    in_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst in_ready0", 32'(rdy0), 0);
    chk("rst in_ready1", 32'(rdy1), 0);
    tick();
    rst = 1'b0; out_ready = '1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chk("rst no stale0", 32'(ov0), 0);
      chk("rst no stale1", 32'(ov1), 0);
      tick();
    end

    // Streaming at occupancy 3
    idle(6);
    out_ready[0] = 1'b0; in_dest = '0; in_valid = 4'b0001;
    k = 0; in_data[0] = 32'h500;
    for (int j = 0; j < 10 && k < 4; j++) begin
      acc = int'(rdy0[0]);
      tick();
      if (acc != 0) begin k++; in_data[0] = 32'h500 + 32'(k); end
    end
    chk("stream fill", k, 4);
    out_ready[0] = 1'b1;
    prev = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk("stream in_ready", 32'(rdy0[0]), 1);
      chk("stream valid", 32'(ov0[0]), 1);
      chk("stream data", od0[0], 32'h500 + 32'(j));
      acc = int'(rdy0[0]);
      tick();
      if (acc != 0) begin k++; in_data[0] = 32'h500 + 32'(k); end
    end

    // Randomized traffic
    idle(10);
    for (int j = 0; j < 400; j++) begin
      in_valid  = 4'($urandom);
      out_ready = 4'($urandom);
      for (int i = 0; i < NI; i++) begin
        in_dest[i] = 2'($urandom_range(0, 3));
        in_data[i] = $urandom;
      end
      rst = ($urandom_range(0, 63) == 0);
      tick();
    end
    rst = 1'b0;
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
